// File: rtl/mcu_playlist_if.sv
// Bus between the button front-end / player chain and the playlist controller.
// Every input is a one-cycle event pulse (no ready: each asserted cycle is one event); outputs are registered.
interface mcu_playlist_if #(
  parameter int SONG_BITS = 2
);
  logic                 play_button;
  logic                 next_button;
  logic                 prev_button;
  logic                 song_done;
  logic                 jump_valid;
  logic [SONG_BITS-1:0] jump_song;
  logic [1:0]           mode;
  logic                 play;
  logic                 reset_player;
  logic [SONG_BITS-1:0] song;

  modport master (
    output play_button, next_button, prev_button, song_done,
    output jump_valid, jump_song, mode,
    input  play, reset_player, song
  );

  modport slave (
    input  play_button, next_button, prev_button, song_done,
    input  jump_valid, jump_song, mode,
    output play, reset_player, song
  );
endinterface

// File: rtl/mcu_playlist.sv
// Playlist control unit: current song index, play/pause state and a restart
// pulse for the player, with prioritised jump/next/prev/song_done/play events.
module mcu_playlist #(
  parameter int NUM_SONGS = 4,
  parameter int SONG_BITS = 2
) (
  input  logic          clk,
  input  logic          reset,
  mcu_playlist_if.slave bus
);
  localparam logic [SONG_BITS-1:0] LAST  = SONG_BITS'(NUM_SONGS - 1);
  // One extra bit so NUM_SONGS itself is representable (e.g. 256 songs, 8-bit index).
  localparam logic [SONG_BITS:0]   COUNT = (SONG_BITS + 1)'(NUM_SONGS);

  typedef enum logic {PAUSED = 1'b0, PLAYING = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [SONG_BITS-1:0] song_q, song_d;
  logic                 rp_q, rp_d;
  logic                 jump_ok;
  logic [SONG_BITS-1:0] song_inc, song_dec;

  assign jump_ok  = bus.jump_valid && ({1'b0, bus.jump_song} < COUNT);
  assign song_inc = (song_q == LAST) ? '0 : song_q + SONG_BITS'(1);
  assign song_dec = (song_q == '0) ? LAST : song_q - SONG_BITS'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PAUSED;
      song_q  <= '0;
      rp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      rp_q    <= rp_d;
    end
  end

  // Exactly one event per cycle; lower-priority simultaneous events are dropped.
  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    rp_d    = 1'b0;
    if (jump_ok) begin
      song_d = bus.jump_song;
      rp_d   = 1'b1;
    end else if (bus.next_button) begin
      song_d = song_inc;
      rp_d   = 1'b1;
    end else if (bus.prev_button) begin
      song_d = song_dec;
      rp_d   = 1'b1;
    end else if (bus.song_done && (state_q == PLAYING)) begin
      rp_d = 1'b1;
      case (bus.mode)
        2'd1: song_d = song_q;
        2'd2: begin
          if (song_q == LAST) begin
            song_d  = '0;
            state_d = PAUSED;
          end else begin
            song_d = song_inc;
          end
        end
        default: song_d = song_inc;
      endcase
    end else if (bus.play_button) begin
      state_d = (state_q == PLAYING) ? PAUSED : PLAYING;
    end
  end

  assign bus.play         = (state_q == PLAYING);
  assign bus.song         = song_q;
  assign bus.reset_player = rp_q;
endmodule

// File: tb/tb_mcu_playlist.sv
// Directed bench for mcu_playlist with NUM_SONGS=5: a behavioural model feeds an
// expected queue checked every cycle, plus hand-computed literal expectations.
module tb_mcu_playlist;
  localparam int NUM = 5;
  localparam int SB  = 3;
  localparam int W   = SB + 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  mcu_playlist_if #(.SONG_BITS(SB)) bus ();

  mcu_playlist #(.NUM_SONGS(NUM), .SONG_BITS(SB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain integer arithmetic over the event priority rules.
  int m_song = 0;
  int m_play = 0;
  int m_rp   = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_song = 0; m_play = 0; m_rp = 1;
    end else begin
      m_rp = 0;
      if (bus.jump_valid && int'(bus.jump_song) < NUM) begin
        m_song = int'(bus.jump_song); m_rp = 1;
      end else if (bus.next_button) begin
        m_song = (m_song + 1) % NUM; m_rp = 1;
      end else if (bus.prev_button) begin
        m_song = (m_song + NUM - 1) % NUM; m_rp = 1;
      end else if (bus.song_done && m_play == 1) begin
        m_rp = 1;
        if (bus.mode == 2'd1) begin
          m_song = m_song;
        end else if (bus.mode == 2'd2 && m_song == NUM - 1) begin
          m_song = 0; m_play = 0;
        end else begin
          m_song = (m_song + 1) % NUM;
        end
      end else if (bus.play_button) begin
        m_play = 1 - m_play;
      end
    end
    exp_q.push_back({m_play[0], m_rp[0], m_song[SB-1:0]});
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.play, bus.reset_player, bus.song} !== e)
        begin
          failures++;
          $display("FAIL model_cmp t=%0t: play=%0b rp=%0b song=%0d expected play=%0b rp=%0b song=%0d",
                   $time, bus.play, bus.reset_player, bus.song, e[W-1], e[W-2], e[SB-1:0]);
        end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    bus.play_button = 1'b0;
    bus.next_button = 1'b0;
    bus.prev_button = 1'b0;
    bus.song_done   = 1'b0;
    bus.jump_valid  = 1'b0;
    bus.jump_song   = '0;
  endtask

  task automatic pulse(input logic pb, input logic nb, input logic prb, input logic sd,
                       input logic jv, input logic [SB-1:0] js, input logic [1:0] md);
    bus.play_button = pb;
    bus.next_button = nb;
    bus.prev_button = prb;
    bus.song_done   = sd;
    bus.jump_valid  = jv;
    bus.jump_song   = js;
    bus.mode        = md;
    step();
    clear();
  endtask

  task automatic chk(input string name, input int s, input int p, input int r);
    checks++;
    if (bus.song !== s[SB-1:0] || bus.play !== p[0] || bus.reset_player !== r[0]) begin
      failures++;
      $display("FAIL %s: song=%0d play=%0b rp=%0b expected song=%0d play=%0d rp=%0d",
               name, bus.song, bus.play, bus.reset_player, s, p, r);
    end
  endtask

  initial begin
    int exp_next[5] = '{1, 2, 3, 4, 0};
    reset = 1'b1;
    bus.mode = 2'd0;
    clear();

    step(); chk("reset_edge1", 0, 0, 1);
    step(); chk("reset_edge2", 0, 0, 1);
    reset = 1'b0;
    step(); chk("reset_release", 0, 0, 0);

    for (int i = 0; i < 5; i++) begin
      pulse(0, 1, 0, 0, 0, 3'd0, 2'd0); chk("next_wrap", exp_next[i], 0, 1);
      step();                          chk("next_idle", exp_next[i], 0, 0);
    end

    pulse(0, 0, 1, 0, 0, 3'd0, 2'd0); chk("prev_wrap", 4, 0, 1);
    pulse(0, 1, 1, 0, 0, 3'd0, 2'd0); chk("next_over_prev", 0, 0, 1);
    pulse(0, 1, 0, 0, 1, 3'd2, 2'd0); chk("jump_over_next", 2, 0, 1);
    pulse(0, 0, 0, 0, 1, 3'd6, 2'd0); chk("jump_oor", 2, 0, 0);
    pulse(0, 1, 0, 0, 1, 3'd6, 2'd0); chk("jump_oor_next", 3, 0, 1);
    pulse(0, 0, 0, 0, 1, 3'd5, 2'd0); chk("jump_eq_num", 3, 0, 0);
    pulse(0, 0, 0, 0, 1, 3'd4, 2'd0); chk("jump_last", 4, 0, 1);
    pulse(0, 0, 0, 0, 1, 3'd4, 2'd0); chk("jump_same", 4, 0, 1);

    pulse(1, 0, 0, 0, 0, 3'd0, 2'd0); chk("play_on", 4, 1, 0);
    pulse(0, 0, 0, 1, 0, 3'd0, 2'd0); chk("done_m0", 0, 1, 1);
    pulse(0, 0, 1, 0, 0, 3'd0, 2'd0); chk("prev_to_last", 4, 1, 1);
    pulse(0, 0, 0, 1, 0, 3'd0, 2'd1); chk("done_m1", 4, 1, 1);
    pulse(0, 0, 0, 1, 0, 3'd0, 2'd3); chk("done_m3", 0, 1, 1);
    pulse(0, 0, 1, 0, 0, 3'd0, 2'd3); chk("prev_to_last2", 4, 1, 1);
    pulse(0, 0, 0, 1, 0, 3'd0, 2'd2); chk("done_m2_last", 0, 0, 1);
    pulse(0, 0, 0, 1, 0, 3'd0, 2'd2); chk("done_paused_m2", 0, 0, 0);
    pulse(0, 0, 0, 1, 0, 3'd0, 2'd0); chk("done_paused_m0", 0, 0, 0);

    pulse(1, 0, 0, 0, 0, 3'd0, 2'd0); chk("play_on2", 0, 1, 0);
    pulse(0, 0, 0, 1, 0, 3'd0, 2'd2); chk("done_m2_mid", 1, 1, 1);

    bus.next_button = 1'b1;
    step(); chk("next_held1", 2, 1, 1);
    step(); chk("next_held2", 3, 1, 1);
    step(); chk("next_held3", 4, 1, 1);
    clear();

    pulse(1, 0, 1, 0, 0, 3'd0, 2'd0); chk("prev_over_play", 3, 1, 1);
    pulse(1, 0, 0, 0, 0, 3'd0, 2'd0); chk("play_off", 3, 0, 0);
    pulse(1, 0, 0, 0, 0, 3'd0, 2'd0); chk("play_t1", 3, 1, 0);
    pulse(1, 0, 0, 0, 0, 3'd0, 2'd0); chk("play_t2", 3, 0, 0);
    pulse(1, 0, 0, 0, 0, 3'd0, 2'd0); chk("play_t3", 3, 1, 0);

    reset = 1'b1;
    pulse(0, 1, 0, 0, 0, 3'd0, 2'd0); chk("reset_mid", 0, 0, 1);
    reset = 1'b0;
    step(); chk("reset_mid_release", 0, 0, 0);

    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mcu_playlist.md
Name: mcu_playlist

Overview:
- Parametrised music-player control unit: tracks the current song index, play/pause state and player-reset pulse for a playlist of NUM_SONGS entries.
- Sits between the debounced button front-end and the song_reader/note_player chain.
- Generalises the fixed 4-song controller with:
  - an arbitrary, non-power-of-2 song count;
  - a previous-song button;
  - a direct jump-to-song request;
  - three end-of-song modes (sequential wrap, repeat-one, stop-at-end).

Parameters:
NUM_SONGS, 4, number of songs in the playlist; legal range 2..256
SONG_BITS, 2, width of song index; must satisfy 2^SONG_BITS >= NUM_SONGS

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
play_button  input  1  one-cycle pulse; toggles play/pause
next_button  input  1  one-cycle pulse; advance to next song
prev_button  input  1  one-cycle pulse; go to previous song
song_done  input  1  one-cycle pulse from player; current song finished
jump_valid  input  1  one-cycle pulse; load jump_song as current song
jump_song  input  SONG_BITS  target index for jump_valid
mode  input  2  end-of-song mode: 0 sequential, 1 repeat-one, 2 stop-at-end, 3 treated as 0
play  output  1  1 = player running
reset_player  output  1  one-cycle pulse; player must restart current song from beginning
song  output  SONG_BITS  current song index, always < NUM_SONGS

Behaviour:
- All outputs are registered. An event sampled at rising edge k is visible on outputs immediately after edge k; latency is 1 cycle.
- Reset (synchronous, highest priority):
  - Edge with reset=1 sets song=0, play=0, reset_player=1. All other inputs are ignored.
  - The first edge with reset=0 and no event returns reset_player to 0.
- reset_player defaults to 0 every cycle unless an event below sets it.
- Event priority, one event processed per cycle; lower-priority simultaneous events are dropped, not queued:
  1. reset
  2. jump
  3. next
  4. prev
  5. song_done
  6. play_button
- States: PAUSED (play=0) and PLAYING (play=1).
- jump_valid:
  - If jump_song < NUM_SONGS: song=jump_song, reset_player=1, play unchanged. This applies even when jump_song equals the current song.
  - If jump_song >= NUM_SONGS: the jump is treated as absent and the next-priority event is processed.
- next_button:
  - song = (song==NUM_SONGS-1) ? 0 : song+1.
  - reset_player=1; play unchanged.
- prev_button:
  - song = (song==0) ? NUM_SONGS-1 : song-1.
  - reset_player=1; play unchanged.
- song_done: honoured only in PLAYING; ignored in PAUSED (no output change).
  - mode 0/3: advance with wrap as for next; reset_player=1; play stays 1.
  - mode 1: song unchanged; reset_player=1; play stays 1.
  - mode 2, song < NUM_SONGS-1: advance; reset_player=1; play stays 1.
  - mode 2, song == NUM_SONGS-1: song=0; reset_player=1; play=0 (enter PAUSED).
- play_button: toggles between PAUSED and PLAYING. reset_player stays 0 and song is unchanged.
- Continuous input events: a button held high for N cycles counts as N events. Example: next held 3 cycles advances 3 songs, with reset_player high for all 3 cycles.
- mode is sampled only on the song_done cycle, so it may change at any time.
- Arithmetic:
  - Index compares use full SONG_BITS width.
  - No modulo operator; wrap uses explicit compare against NUM_SONGS-1.
  - song never holds a value >= NUM_SONGS.

Test Plan:
- Reset then idle, NUM_SONGS=5: assert reset 2 cycles, release → song=0, play=0, reset_player=1 on the reset edge, then 0 one cycle after release.
- Next wrap, NUM_SONGS=5: 5 single-cycle next pulses from song 0 → song 1,2,3,4,0, each with a 1-cycle reset_player pulse; play unchanged.
- Prev wrap and priority: prev at song 0 → song=4. Then next+prev together at song 4 → song=0 (next wins). Then jump_valid with jump_song=2 plus next → song=2.
- Jump out of range: jump_song=6 with NUM_SONGS=5 and jump_valid=1 → song unchanged, reset_player=0. Same stimulus with next_button=1 → next is processed.
- End-of-song modes, playing song 4:
  - song_done in mode 0 → song=0, play=1.
  - Back to song 4, song_done in mode 1 → song=4, reset_player=1, play=1.
  - song_done in mode 2 → song=0, play=0, reset_player=1.
  - Further song_done pulses while paused → no change.
- Play toggle and mid-operation reset: 3 play pulses → play 1,0,1, reset_player=0 throughout. Then reset while playing song 3 → song=0, play=0, reset_player=1.
